// File: rtl/mmc1_mapper.sv
// MMC1-compatible bank controller: serial register load port, PRG/CHR BRAM
// address translation and CIRAM A10 mirroring control.
module mmc1_mapper #(
    parameter int PRG_AW = 18,
    parameter int CHR_AW = 17
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              prg_nce_in,
    input  logic [14:0]       prg_a_in,
    input  logic              prg_r_nw_in,
    input  logic [7:0]        prg_d_in,
    input  logic [13:0]       chr_a_in,
    output logic [PRG_AW-1:0] prg_rom_a,
    output logic [CHR_AW-1:0] chr_rom_a,
    output logic              ciram_nce_out,
    output logic              ciram_a10_out
);

    typedef enum logic [1:0] {
        SEL_CTRL = 2'd0,
        SEL_CHR0 = 2'd1,
        SEL_CHR1 = 2'd2,
        SEL_PRG  = 2'd3
    } reg_sel_e;

    logic [4:0]  shift;
    logic [4:0]  ctrl;
    logic [4:0]  chr0;
    logic [4:0]  chr1;
    logic [4:0]  prg;
    logic        wr;
    logic        wr_q;
    logic        accept;
    logic [4:0]  shift_next;
    reg_sel_e    sel;
    logic [3:0]  prg_bank;
    logic [17:0] prg_full;
    logic [4:0]  chr_bank;
    logic [16:0] chr_full;
    logic        unused_bits;

    assign wr         = ~prg_nce_in & ~prg_r_nw_in;
    assign accept     = wr & ~wr_q;
    assign shift_next = {prg_d_in[0], shift[4:1]};
    assign sel        = reg_sel_e'(prg_a_in[14:13]);

    // The marker bit reaching shift[0] means this write supplies the fifth bit.
    always_ff @(posedge clk_sys) begin
        if (!rst) begin
            shift <= 5'b10000;
            ctrl  <= 5'b01100;
            chr0  <= '0;
            chr1  <= '0;
            prg   <= '0;
            wr_q  <= 1'b0;
        end else begin
            wr_q <= wr;
            if (accept) begin
                if (prg_d_in[7]) begin
                    shift     <= 5'b10000;
                    ctrl[3:2] <= 2'b11;
                end else if (!shift[0]) begin
                    shift <= shift_next;
                end else begin
                    shift <= 5'b10000;
                    case (sel)
                        SEL_CTRL: ctrl <= shift_next;
                        SEL_CHR0: chr0 <= shift_next;
                        SEL_CHR1: chr1 <= shift_next;
                        SEL_PRG:  prg  <= shift_next;
                        default:  ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        prg_bank = prg[3:0];
        case (ctrl[3:2])
            2'd0, 2'd1: prg_bank = {prg[3:1], prg_a_in[14]};
            2'd2:       prg_bank = prg_a_in[14] ? prg[3:0] : '0;
            default:    prg_bank = prg_a_in[14] ? '1 : prg[3:0];
        endcase
        prg_full = {prg_bank, prg_a_in[13:0]};
    end

    // 8K mode folds A12 into the bank LSB so both modes share one 4 KB layout.
    always_comb begin
        if (ctrl[4]) begin
            chr_bank = chr_a_in[12] ? chr1 : chr0;
        end else begin
            chr_bank = {chr0[4:1], chr_a_in[12]};
        end
        chr_full = {chr_bank, chr_a_in[11:0]};
    end

    always_comb begin
        ciram_a10_out = 1'b0;
        case (ctrl[1:0])
            2'd0:    ciram_a10_out = 1'b0;
            2'd1:    ciram_a10_out = 1'b1;
            2'd2:    ciram_a10_out = chr_a_in[10];
            default: ciram_a10_out = chr_a_in[11];
        endcase
    end

    assign prg_rom_a     = prg_full[PRG_AW-1:0];
    assign chr_rom_a     = chr_full[CHR_AW-1:0];
    assign ciram_nce_out = ~chr_a_in[13];
    assign unused_bits   = ^{prg[4], prg_d_in[6:1]};

endmodule

// File: tb/tb_mmc1_mapper.sv
// Scoreboarded bench for mmc1_mapper: stimulus pushes expectations from a
// register-level reference model, a negedge monitor pops and compares.
module tb_mmc1_mapper;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b0;
    logic        prg_nce_in = 1'b1;
    logic [14:0] prg_a_in = '0;
    logic        prg_r_nw_in = 1'b1;
    logic [7:0]  prg_d_in = '0;
    logic [13:0] chr_a_in = '0;
    logic [17:0] prg_rom_a;
    logic [16:0] chr_rom_a;
    logic        ciram_nce_out;
    logic        ciram_a10_out;

    mmc1_mapper #(.PRG_AW(18), .CHR_AW(17)) dut (
        .clk_sys       (clk_sys),
        .rst           (rst),
        .prg_nce_in    (prg_nce_in),
        .prg_a_in      (prg_a_in),
        .prg_r_nw_in   (prg_r_nw_in),
        .prg_d_in      (prg_d_in),
        .chr_a_in      (chr_a_in),
        .prg_rom_a     (prg_rom_a),
        .chr_rom_a     (chr_rom_a),
        .ciram_nce_out (ciram_nce_out),
        .ciram_a10_out (ciram_a10_out)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        string       name;
        logic [17:0] prg;
        logic [16:0] chr;
        logic        a10;
        logic        nce;
    } exp_t;

    exp_t sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    // Reference model: registers as integers, serial load as bit count + accumulator.
    int unsigned m_ctrl, m_chr0, m_chr1, m_prg, m_cnt, m_acc;

    task automatic model_reset();
        m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0; m_cnt = 0; m_acc = 0;
    endtask

    task automatic model_write(input logic [14:0] a, input logic [7:0] d);
        if (d[7]) begin
            m_cnt = 0; m_acc = 0; m_ctrl = m_ctrl | 12;
        end else begin
            m_acc = m_acc + (int'(d[0]) << m_cnt);
            m_cnt++;
            if (m_cnt == 5) begin
                case (a / 8192)
                    0: m_ctrl = m_acc;
                    1: m_chr0 = m_acc;
                    2: m_chr1 = m_acc;
                    default: m_prg = m_acc;
                endcase
                m_cnt = 0; m_acc = 0;
            end
        end
    endtask

    function automatic logic [17:0] exp_prg(input logic [14:0] a);
        int unsigned mode, bank, r;
        mode = (m_ctrl / 4) % 4;
        bank = 0;
        if (mode < 2) begin
            r = (m_prg / 2) * 32768 + a;
        end else begin
            if (mode == 2) bank = a[14] ? m_prg % 16 : 0;
            else           bank = a[14] ? 15 : m_prg % 16;
            r = bank * 16384 + (a % 16384);
        end
        return 18'(r % 262144);
    endfunction

    function automatic logic [16:0] exp_chr(input logic [13:0] a);
        int unsigned r;
        if ((m_ctrl / 16) % 2 == 0) r = (m_chr0 / 2) * 8192 + (a % 8192);
        else r = (((a / 4096) % 2 == 1) ? m_chr1 : m_chr0) * 4096 + (a % 4096);
        return 17'(r % 131072);
    endfunction

    function automatic logic exp_a10(input logic [13:0] a);
        case (m_ctrl % 4)
            0: return 1'b0;
            1: return 1'b1;
            2: return a[10];
            default: return a[11];
        endcase
    endfunction

    task automatic push_model(input string name);
        exp_t e;
        e.name = name;
        e.prg  = exp_prg(prg_a_in);
        e.chr  = exp_chr(chr_a_in);
        e.a10  = exp_a10(chr_a_in);
        e.nce  = ~chr_a_in[13];
        sb.push_back(e);
    endtask

    // Idle bus lookup; optional fixed expectations override the model.
    task automatic look(input string name, input logic [14:0] pa, input logic [13:0] ca,
                        input bit fix_p, input logic [17:0] ep,
                        input bit fix_c, input logic [16:0] ec);
        exp_t e;
        prg_a_in = pa; chr_a_in = ca;
        e.name = name;
        e.prg  = fix_p ? ep : exp_prg(pa);
        e.chr  = fix_c ? ec : exp_chr(ca);
        e.a10  = exp_a10(ca);
        e.nce  = ~ca[13];
        sb.push_back(e);
        @(posedge clk_sys); #1;
    endtask

    task automatic look_a10(input string name, input logic [13:0] ca, input logic ea10);
        exp_t e;
        chr_a_in = ca;
        e.name = name;
        e.prg  = exp_prg(prg_a_in);
        e.chr  = exp_chr(ca);
        e.a10  = ea10;
        e.nce  = ~ca[13];
        sb.push_back(e);
        @(posedge clk_sys); #1;
    endtask

    task automatic bus_write(input logic [14:0] a, input logic [7:0] d, input int unsigned hold);
        prg_nce_in = 1'b0; prg_r_nw_in = 1'b0; prg_a_in = a; prg_d_in = d;
        chr_a_in = 14'($urandom);
        push_model("pre_write");
        @(posedge clk_sys); #1;
        model_write(a, d);
        push_model("post_write");
        for (int unsigned i = 1; i < hold; i++) begin
            @(posedge clk_sys); #1;
            push_model("write_hold");
        end
        prg_nce_in = 1'b1; prg_r_nw_in = 1'b1;
        @(posedge clk_sys); #1;
    endtask

    task automatic serial_load(input logic [14:0] a, input int unsigned v);
        for (int unsigned i = 0; i < 5; i++) begin
            bus_write(a, 8'((v >> i) & 1), 1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk_sys); #1;
        model_reset();
        rst = 1'b1;
        push_model("post_reset");
        @(posedge clk_sys); #1;
    endtask

    task automatic check_field(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h at %0t", n, f, act, exp, $time);
        end
    endtask

    always @(negedge clk_sys) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_field(e.name, "prg_rom_a", 32'(prg_rom_a), 32'(e.prg));
            check_field(e.name, "chr_rom_a", 32'(chr_rom_a), 32'(e.chr));
            check_field(e.name, "ciram_a10", 32'(ciram_a10_out), 32'(e.a10));
            check_field(e.name, "ciram_nce", 32'(ciram_nce_out), 32'(e.nce));
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        model_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        rst = 1'b1;

        look("reset_hi", 15'h4000, 14'h0000, 1'b1, 18'h3C000, 1'b0, '0);
        look("reset_lo", 15'h0000, 14'h0123, 1'b1, 18'h00000, 1'b0, '0);

        serial_load(15'h6000, 5);
        look("prg5", 15'h0123, 14'h0000, 1'b1, 18'h14123, 1'b0, '0);

        bus_write(15'h6000, 8'h01, 10);
        for (int unsigned i = 0; i < 4; i++) bus_write(15'h6000, 8'h00, 1);
        look("long_write", 15'h0000, 14'h0000, 1'b1, 18'h04000, 1'b0, '0);

        serial_load(15'h0000, 5'b10010);
        serial_load(15'h2000, 3);
        serial_load(15'h4000, 7);
        look("chr_hi", 15'h0000, 14'h1ABC, 1'b0, '0, 1'b1, 17'h07ABC);
        look("chr_lo", 15'h0000, 14'h0ABC, 1'b0, '0, 1'b1, 17'h03ABC);
        look_a10("vert_a10_1", 14'h0400, 1'b1);
        look_a10("vert_a10_0", 14'h0BFF, 1'b0);
        look("nametable", 15'h0000, 14'h2400, 1'b0, '0, 1'b0, '0);

        for (int unsigned i = 0; i < 3; i++) bus_write(15'h6000, 8'h01, 1);
        bus_write(15'h6000, 8'h80, 1);
        serial_load(15'h6000, 9);
        look("after_80_lo", 15'h0000, 14'h0000, 1'b1, 18'h24000, 1'b0, '0);
        look("after_80_hi", 15'h4000, 14'h0000, 1'b1, 18'h3C000, 1'b0, '0);
        look_a10("after_80_a10", 14'h0400, 1'b1);

        for (int unsigned i = 0; i < 3; i++) bus_write(15'h2000, 8'h01, 1);
        do_reset();
        serial_load(15'h2000, 5'h15);
        look("reset_mid_seq", 15'h4000, 14'h0123, 1'b1, 18'h3C000, 1'b1, 17'h14123);

        // Write strobe overlapping reset must be dropped.
        rst = 1'b0; prg_nce_in = 1'b0; prg_r_nw_in = 1'b0; prg_a_in = 15'h6000; prg_d_in = 8'h01;
        @(posedge clk_sys); #1;
        model_reset();
        rst = 1'b1; prg_nce_in = 1'b1; prg_r_nw_in = 1'b1;
        @(posedge clk_sys); #1;
        serial_load(15'h6000, 6);
        look("reset_wins", 15'h0000, 14'h0000, 1'b1, 18'h18000, 1'b0, '0);

        for (int unsigned it = 0; it < 400; it++) begin
            int unsigned k;
            k = $urandom_range(0, 19);
            if (k == 0) begin
                do_reset();
            end else if (k == 1) begin
                bus_write(15'($urandom), 8'($urandom) | 8'h80, 1);
            end else if (k == 2) begin
                prg_nce_in = 1'b1; prg_r_nw_in = 1'b0; prg_d_in = 8'($urandom);
                prg_a_in = 15'($urandom); chr_a_in = 14'($urandom);
                push_model("nce_high_write");
                @(posedge clk_sys); #1;
                prg_r_nw_in = 1'b1;
            end else if (k == 3) begin
                prg_nce_in = 1'b0; prg_r_nw_in = 1'b1; prg_d_in = 8'($urandom);
                prg_a_in = 15'($urandom); chr_a_in = 14'($urandom);
                push_model("cpu_read");
                @(posedge clk_sys); #1;
                prg_nce_in = 1'b1;
            end else begin
                bus_write(15'($urandom), 8'($urandom) & 8'h7F, $urandom_range(1, 3));
            end
            look("rand_look", 15'($urandom), 14'($urandom), 1'b0, '0, 1'b0, '0);
        end

        repeat (2) @(posedge clk_sys);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
